completion_wait_channel: RTL
============================

Name: completion_wait_channel

Overview:
- Initiator-side counterpart to the command channel's completion reporter.
- Accepts a command from a local source, stamps it with this node's ID and issues it downstream.
- Then holds off further commands until the matching completion report returns on a separate completion input, or until a timeout expires.
- Gives single-outstanding, completion-ordered command issue for a node on the inner command interface.

Parameters:
AddressWidth, 32, width of address field
InnerIFLengthWidth, 16, width of length field
ThisID, 1, 5-bit node ID stamped into issued commands' SourceID
TimeoutWidth, 16, width of the wait-cycle counter
TimeoutCycles, 1000, cycles in WaitCmplt before abort; 0 disables timeout

Ports:
iClock  in  1  clock
iReset  in  1  synchronous active-high reset
iSrcOpcode  in  6  source command opcode
iSrcTargetID  in  5  source command target ID
iSrcAddress  in  AddressWidth  source command address
iSrcLength  in  InnerIFLengthWidth  source command length
iSrcCmdValid  in  1  source command valid
oSrcCmdReady  out  1  source command ready
oDstOpcode  out  6  issued opcode
oDstTargetID  out  5  issued target ID
oDstSourceID  out  5  issued source ID (always ThisID)
oDstAddress  out  AddressWidth  issued address
oDstLength  out  InnerIFLengthWidth  issued length
oDstCmdValid  out  1  issued command valid
iDstCmdReady  in  1  issued command ready
iCmpltOpcode  in  6  returning completion opcode
iCmpltTargetID  in  5  returning completion target ID
iCmpltSourceID  in  5  returning completion source ID
iCmpltAddress  in  AddressWidth  returning completion address
iCmpltLength  in  InnerIFLengthWidth  returning completion length
iCmpltValid  in  1  completion valid
oCmpltReady  out  1  completion ready
oBusy  out  1  command outstanding (state != Idle)
oDone  out  1  one-cycle pulse: matching completion received
oMismatch  out  1  one-cycle pulse: non-matching completion discarded
oTimeout  out  1  one-cycle pulse: wait aborted by timeout

Behaviour:
- Handshakes are valid/ready; a transfer occurs on a cycle with valid && ready high.
- The FSM state register and the latch registers are clocked. Encodings: Idle=2'b00, ForwardReq=2'b01, WaitCmplt=2'b11.
- Reset (iReset high at posedge): state=Idle, all latched fields=0, wait counter=0, oDone/oMismatch/oTimeout=0.
- Combinational outputs after reset: oSrcCmdReady=1, oDstCmdValid=0, oCmpltReady=0, oBusy=0.
- Reset mid-operation abandons the outstanding command with no pulse.

Idle:
- oSrcCmdReady=1.
- On source transfer, latch opcode, target, address, length; SourceID field is forced to ThisID.
- iSrcLength==0: command dropped, stay Idle, nothing issued.
- Otherwise go to ForwardReq.

ForwardReq:
- oDstCmdValid=1; oDst* are driven from the latched registers and stay stable while stalled.
- iDstCmdReady=1 -> WaitCmplt, wait counter cleared to 0.
- Latency: the source transfer at cycle N gives oDstCmdValid high from cycle N+1.

WaitCmplt:
- oCmpltReady=1; the counter increments once per cycle, saturating.
- A completion transfer matches when all hold: opcode==0, TargetID==0, SourceID==latched target, length==1, address==latched address.
- Match -> Idle; oDone=1 for the following cycle.
- Non-match -> completion consumed, stay in WaitCmplt, counter not reset; oMismatch=1 for the following cycle.
- Timeout: TimeoutCycles!=0 and counter==TimeoutCycles-1 with no match this cycle -> Idle; oTimeout=1 for the following cycle.
- Same-cycle match and timeout: match wins (oDone only).
- oCmpltReady=0 in Idle and ForwardReq; completions presented there are held off, not dropped.

General:
- Pulses are registered and last exactly one cycle.
- Pulses are mutually exclusive.
- A new source command is accepted in the cycle after return to Idle (oSrcCmdReady combinational on state).
- Length and address are compared at full width with no truncation.
- Counter width is TimeoutWidth; TimeoutCycles must fit in it.

Test Plan:
1. Reset, then src {op=6'h05, tgt=2, addr=0x1000, len=8}, iDstCmdReady=1 -> oDstCmdValid at N+1 with SourceID=1, tgt=2, addr=0x1000, len=8. Then completion {op=0, tgt=0, src=2, addr=0x1000, len=1} -> oDone pulse, oBusy falls, oSrcCmdReady=1.
2. Src command with len=0 -> no oDstCmdValid, oBusy stays 0, oSrcCmdReady stays 1.
3. Hold iDstCmdReady=0 for 5 cycles in ForwardReq -> oDstCmdValid stays high and oDst* stable; iSrcCmdValid pulses are ignored (oSrcCmdReady=0).
4. In WaitCmplt, send completion with src=3 -> oMismatch pulse, still busy; then send correct completion -> oDone.
5. TimeoutCycles=10, no completion -> oTimeout pulse exactly 10 cycles after the downstream transfer. Repeat with matching completion on cycle 10 -> oDone only.
6. Assert iReset during WaitCmplt -> next cycle Idle, all pulses 0, oCmpltReady=0, a subsequent command issues normally.

Source files
------------

// File: rtl/completion_wait_channel.sv
// Initiator-side command channel: stamps a local command with this node's ID, issues it
// downstream, then blocks further commands until the matching completion or a timeout.
module completion_wait_channel #(
  parameter int AddressWidth       = 32,
  parameter int InnerIFLengthWidth = 16,
  parameter int ThisID             = 1,
  parameter int TimeoutWidth       = 16,
  parameter int TimeoutCycles      = 1000
) (
  input  logic                          iClock,
  input  logic                          iReset,
  input  logic [5:0]                    iSrcOpcode,
  input  logic [4:0]                    iSrcTargetID,
  input  logic [AddressWidth-1:0]       iSrcAddress,
  input  logic [InnerIFLengthWidth-1:0] iSrcLength,
  input  logic                          iSrcCmdValid,
  output logic                          oSrcCmdReady,
  output logic [5:0]                    oDstOpcode,
  output logic [4:0]                    oDstTargetID,
  output logic [4:0]                    oDstSourceID,
  output logic [AddressWidth-1:0]       oDstAddress,
  output logic [InnerIFLengthWidth-1:0] oDstLength,
  output logic                          oDstCmdValid,
  input  logic                          iDstCmdReady,
  input  logic [5:0]                    iCmpltOpcode,
  input  logic [4:0]                    iCmpltTargetID,
  input  logic [4:0]                    iCmpltSourceID,
  input  logic [AddressWidth-1:0]       iCmpltAddress,
  input  logic [InnerIFLengthWidth-1:0] iCmpltLength,
  input  logic                          iCmpltValid,
  output logic                          oCmpltReady,
  output logic                          oBusy,
  output logic                          oDone,
  output logic                          oMismatch,
  output logic                          oTimeout
);

  typedef enum logic [1:0] {
    Idle       = 2'b00,
    ForwardReq = 2'b01,
    WaitCmplt  = 2'b11
  } state_t;

  localparam logic [4:0] ThisIdBits = 5'(ThisID);
  localparam bit TimeoutEnable = (TimeoutCycles != 0);
  localparam logic [TimeoutWidth-1:0] TimeoutLast =
    TimeoutWidth'((TimeoutCycles == 0) ? 0 : TimeoutCycles - 1);

  state_t state, state_next;

  logic [5:0]                    opcode_q;
  logic [4:0]                    target_q;
  logic [AddressWidth-1:0]       address_q;
  logic [InnerIFLengthWidth-1:0] length_q;
  logic [TimeoutWidth-1:0]       wait_count;
  logic                          done_q, mismatch_q, timeout_q;

  logic src_fire, dst_fire, cmplt_fire, cmplt_match, timeout_hit;
  logic in_wait, match_fire;

  assign oSrcCmdReady = (state == Idle);
  assign oDstCmdValid = (state == ForwardReq);
  assign oCmpltReady  = (state == WaitCmplt);
  assign oBusy        = (state != Idle);

  assign oDstOpcode   = opcode_q;
  assign oDstTargetID = target_q;
  assign oDstSourceID = ThisIdBits;
  assign oDstAddress  = address_q;
  assign oDstLength   = length_q;

  assign oDone     = done_q;
  assign oMismatch = mismatch_q;
  assign oTimeout  = timeout_q;

  assign src_fire   = iSrcCmdValid & oSrcCmdReady;
  assign dst_fire   = oDstCmdValid & iDstCmdReady;
  assign cmplt_fire = iCmpltValid & oCmpltReady;
  assign in_wait    = (state == WaitCmplt);

  // A completion belongs to us when it is addressed back to the node we targeted.
  assign cmplt_match = (iCmpltOpcode == 6'd0) &&
                       (iCmpltTargetID == 5'd0) &&
                       (iCmpltSourceID == target_q) &&
                       (iCmpltLength == InnerIFLengthWidth'(1)) &&
                       (iCmpltAddress == address_q);

  assign match_fire  = cmplt_fire & cmplt_match;
  assign timeout_hit = TimeoutEnable && (wait_count == TimeoutLast);

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state <= Idle;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      Idle: begin
        if (src_fire && (iSrcLength != '0)) state_next = ForwardReq;
      end
      ForwardReq: begin
        if (dst_fire) state_next = WaitCmplt;
      end
      WaitCmplt: begin
        if (match_fire || timeout_hit) state_next = Idle;
      end
      default: state_next = Idle;
    endcase
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      opcode_q  <= '0;
      target_q  <= '0;
      address_q <= '0;
      length_q  <= '0;
    end else if (src_fire) begin
      opcode_q  <= iSrcOpcode;
      target_q  <= iSrcTargetID;
      address_q <= iSrcAddress;
      length_q  <= iSrcLength;
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      wait_count <= '0;
    end else if (dst_fire) begin
      wait_count <= '0;
    end else if (in_wait && (wait_count != '1)) begin
      wait_count <= wait_count + 1'b1;
    end
  end

  // A stray completion arriving on the timeout cycle reports only the timeout,
  // keeping the three pulses mutually exclusive.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      done_q     <= 1'b0;
      mismatch_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      done_q     <= in_wait && match_fire;
      timeout_q  <= in_wait && !match_fire && timeout_hit;
      mismatch_q <= in_wait && cmplt_fire && !cmplt_match && !timeout_hit;
    end
  end

endmodule
